// File: rtl/dsc_op_sequencer.sv
// dsc_op_sequencer: drives one DSC core operation at a time.
//   IDLE  -> capture the operands and the run-cycle budget.
//   CLEAR -> hold the core in reset for one cycle.
//   RUN   -> enable the core and count run cycles.
//   DONE  -> present the result until the consumer takes it.
// The run stops on the first of these: the core finishes, the budget is
// reached, or the counter saturates.
// Optional feature: define DSC_SEQ_PERF_EN to add the perf_ops and
// perf_cycles performance counters.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an operand set; core held in reset
// CLEAR | one-cycle core reset after capture; counter cleared
// RUN   | core enabled; counter counts RUN cycles
// DONE  | result valid; waiting for out_ready
module dsc_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 2,
  parameter int CNT_WIDTH  = 17
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [CNT_WIDTH-1:0]             cyc_budget,
  output logic                             core_rst,
  output logic                             core_en,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_in,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] core_data_out,
  input  logic                             core_op_finished,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]             out_cycles,
  output logic                             out_trunc,
  output logic                             out_ovf
`ifdef DSC_SEQ_PERF_EN
  ,
  output logic [31:0]                      perf_ops,
  output logic [47:0]                      perf_cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   armed_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   budget_q;
  logic [CNT_WIDTH-1:0]   cnt_cur;
  logic                   accept;
  logic                   fin_hit;
  logic                   bud_hit;
  logic                   sat_hit;
  logic                   term;
  logic                   handshake;

  // Count value of the current RUN cycle, including this one.
  assign cnt_cur   = cnt_q + CNT_WIDTH'(1);
  assign fin_hit   = (state_q == S_RUN) && core_op_finished;
  assign bud_hit   = (state_q == S_RUN) && (budget_q != '0) && (cnt_cur == budget_q);
  assign sat_hit   = (state_q == S_RUN) && (&cnt_cur);
  assign term      = fin_hit || bud_hit || sat_hit;
  assign accept    = in_valid && in_ready;
  assign handshake = (state_q == S_DONE) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_CLEAR;
      S_CLEAR:                state_d = S_RUN;
      S_RUN:   if (term)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Decoded outputs; in_ready also waits for the first edge after reset.
  always_comb begin
    in_ready  = (state_q == S_IDLE) && armed_q;
    core_rst  = (state_q != S_RUN);
    core_en   = (state_q == S_RUN);
    out_valid = (state_q == S_DONE);
  end

  // Keeps in_ready low during reset and up to the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  // Operand capture, run counter and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_data_in <= '0;
      budget_q     <= '0;
      cnt_q        <= '0;
      out_data     <= '0;
      out_cycles   <= '0;
      out_trunc    <= 1'b0;
      out_ovf      <= 1'b0;
    end else begin
      if (accept) begin
        core_data_in <= in_data;
        budget_q     <= cyc_budget;
      end
      if (state_q == S_CLEAR) cnt_q <= '0;
      else if (state_q == S_RUN) cnt_q <= cnt_cur;
      if (term) begin
        // A core finish takes priority; the budget beats saturation.
        out_data   <= core_data_out;
        out_cycles <= cnt_cur;
        out_trunc  <= !fin_hit && bud_hit;
        out_ovf    <= !fin_hit && !bud_hit && sat_hit;
      end
    end
  end

`ifdef DSC_SEQ_PERF_EN
  // Completed-operation and consumed-cycle counters; both wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops    <= '0;
      perf_cycles <= '0;
    end else if (handshake) begin
      perf_ops    <= perf_ops + 32'd1;
      perf_cycles <= perf_cycles + 48'(out_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_dsc_op_sequencer.sv
// Bench for dsc_op_sequencer. It drives a table of directed operations
// through a 17-bit-counter instance and a 4-bit-counter instance, then runs
// hand-written reset, stall and handshake sequences.
module tb_dsc_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv = 1'b0;
  logic        sel4 = 1'b0;
  logic [15:0] in_data = '0;
  logic [16:0] cyc_budget = '0;
  logic [15:0] core_data_out = '0;
  logic        out_ready = 1'b0;
  logic        fin_force = 1'b0;
  int          fin_at = 0;
  int          run_cnt = 0;
  logic        core_op_finished;

  logic        in_ready, core_rst, core_en, out_valid, out_trunc, out_ovf;
  logic [15:0] core_data_in, out_data;
  logic [16:0] out_cycles;
  logic        in_ready4, core_rst4, core_en4, out_valid4, out_trunc4, out_ovf4;
  logic [15:0] core_data_in4, out_data4;
  logic [3:0]  out_cycles4;
`ifdef DSC_SEQ_PERF_EN
  logic [31:0] perf_ops;
  logic [47:0] perf_cycles;
  logic [31:0] perf_ops4;
  logic [47:0] perf_cycles4;
`endif

  logic        m_in_ready, m_core_rst, m_core_en, m_out_valid, m_out_trunc, m_out_ovf;
  logic [15:0] m_core_data_in, m_out_data;
  logic [16:0] m_out_cycles;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dsc_op_sequencer #(.DATA_WIDTH(8), .NUM_INPUTS(2), .CNT_WIDTH(17)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && !sel4), .in_ready(in_ready), .in_data(in_data),
    .cyc_budget(cyc_budget),
    .core_rst(core_rst), .core_en(core_en), .core_data_in(core_data_in),
    .core_data_out(core_data_out), .core_op_finished(core_op_finished),
    .out_valid(out_valid), .out_ready(out_ready && !sel4), .out_data(out_data),
    .out_cycles(out_cycles), .out_trunc(out_trunc), .out_ovf(out_ovf)
`ifdef DSC_SEQ_PERF_EN
    , .perf_ops(perf_ops), .perf_cycles(perf_cycles)
`endif
  );

  dsc_op_sequencer #(.DATA_WIDTH(8), .NUM_INPUTS(2), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv && sel4), .in_ready(in_ready4), .in_data(in_data),
    .cyc_budget(cyc_budget[3:0]),
    .core_rst(core_rst4), .core_en(core_en4), .core_data_in(core_data_in4),
    .core_data_out(core_data_out), .core_op_finished(core_op_finished),
    .out_valid(out_valid4), .out_ready(out_ready && sel4), .out_data(out_data4),
    .out_cycles(out_cycles4), .out_trunc(out_trunc4), .out_ovf(out_ovf4)
`ifdef DSC_SEQ_PERF_EN
    , .perf_ops(perf_ops4), .perf_cycles(perf_cycles4)
`endif
  );

  assign m_in_ready     = sel4 ? in_ready4     : in_ready;
  assign m_core_rst     = sel4 ? core_rst4     : core_rst;
  assign m_core_en      = sel4 ? core_en4      : core_en;
  assign m_out_valid    = sel4 ? out_valid4    : out_valid;
  assign m_out_trunc    = sel4 ? out_trunc4    : out_trunc;
  assign m_out_ovf      = sel4 ? out_ovf4      : out_ovf;
  assign m_core_data_in = sel4 ? core_data_in4 : core_data_in;
  assign m_out_data     = sel4 ? out_data4     : out_data;
  assign m_out_cycles   = sel4 ? {13'b0, out_cycles4} : out_cycles;

  // Core model: finishes during RUN cycle fin_at (0 = never finishes).
  always @(posedge clk) run_cnt <= m_core_en ? run_cnt + 1 : 0;
  assign core_op_finished = fin_force || (m_core_en && fin_at != 0 && run_cnt + 1 == fin_at);

  typedef struct {
    logic        w4;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [16:0] bud;
    int          fin;
    logic [15:0] res;
    int          exp_cyc;
    logic        exp_t;
    logic        exp_o;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Offer one operand set, then wait for the result under a cycle bound.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [16:0] bud, input int fin, input logic [15:0] res);
    @(negedge clk);
    in_data = {b, a};
    cyc_budget = bud;
    fin_at = fin;
    core_data_out = res;
    iv = 1'b1;
    chk("in_ready_idle", {63'b0, m_in_ready}, 64'd1);
    @(negedge clk);
    iv = 1'b0;
    chk("core_data_in", {48'b0, m_core_data_in}, {48'b0, b, a});
  endtask

  task automatic wait_done(output int k, output int en);
    k = 1;
    en = 0;
    while (!m_out_valid && k < 200) begin
      if (m_core_en) en++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input vec_t v);
    int k, en;
    @(negedge clk);
    sel4 = v.w4;
    start_op(v.a, v.b, v.bud, v.fin, v.res);
    wait_done(k, en);
    chk("latency", 64'(k), 64'(v.exp_cyc + 2));
    chk("core_en_cycles", 64'(en), 64'(v.exp_cyc));
    chk("out_data", {48'b0, m_out_data}, {48'b0, v.res});
    chk("out_cycles", {47'b0, m_out_cycles}, 64'(v.exp_cyc));
    chk("out_trunc", {63'b0, m_out_trunc}, {63'b0, v.exp_t});
    chk("out_ovf", {63'b0, m_out_ovf}, {63'b0, v.exp_o});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_after_hs", {63'b0, m_out_valid}, 64'd0);
    chk("ready_after_hs", {63'b0, m_in_ready}, 64'd1);
  endtask

  initial begin
    int k, en;
    //           w4    a      b      bud     fin  res        cyc  t     o
    tbl[0] = '{1'b0, 8'd3,  8'd5,  17'd0,  40, 16'h1234, 40, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd7,  8'd9,  17'd16, 0,  16'h00ff, 16, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 8'd1,  8'd2,  17'd16, 16, 16'hbeef, 16, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'hff, 8'h80, 17'd5,  3,  16'h0f0f, 3,  1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h11, 8'h22, 17'd1,  0,  16'h5555, 1,  1'b1, 1'b0};
    tbl[5] = '{1'b0, 8'h33, 8'h44, 17'd0,  1,  16'haaaa, 1,  1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h0a, 8'h0b, 17'd0,  0,  16'h1357, 15, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 8'h0c, 8'h0d, 17'd15, 0,  16'h2468, 15, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 8'h0e, 8'h0f, 17'd0,  15, 16'h9abc, 15, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 8'h10, 8'h20, 17'd4,  0,  16'hcdef, 4,  1'b1, 1'b0};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_core_rst", {63'b0, core_rst}, 64'd1);
    chk("rst_core_en", {63'b0, core_en}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", {48'b0, out_data}, 64'd0);
    chk("rst_out_cycles", {47'b0, out_cycles}, 64'd0);
    chk("rst_core_data_in", {48'b0, core_data_in}, 64'd0);
    chk("rst_flags", {62'b0, out_trunc, out_ovf}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {63'b0, in_ready}, 64'd0);
    @(negedge clk);
    chk("ready_first_edge", {63'b0, in_ready}, 64'd1);

    foreach (tbl[i]) run_op(tbl[i]);
    sel4 = 1'b0;

    // Result held while out_ready stays low; core finish ignored in DONE.
    start_op(8'h21, 8'h43, 17'd0, 7, 16'ha55a);
    wait_done(k, en);
    chk("stall_latency", 64'(k), 64'd9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      core_data_out = 16'($urandom);
      fin_force = i[0];
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
      chk("stall_data", {48'b0, out_data}, 64'ha55a);
      chk("stall_cycles", {47'b0, out_cycles}, 64'd7);
    end
    fin_force = 1'b0;
    out_ready = 1'b1;
    iv = 1'b1;
    in_data = 16'h6655;
    cyc_budget = 17'd3;
    fin_at = 0;
    core_data_out = 16'h7777;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid_low", {63'b0, out_valid}, 64'd0);
    chk("hs_idle_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    iv = 1'b0;
    chk("accept_clear_ready", {63'b0, in_ready}, 64'd0);
    chk("accept_clear_rst", {62'b0, core_rst, core_en}, 64'd2);
    chk("accept_data", {48'b0, core_data_in}, 64'h6655);
    wait_done(k, en);
    chk("b2b_cycles", {47'b0, out_cycles}, 64'd3);
    chk("b2b_trunc", {63'b0, out_trunc}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of RUN abandons the operation.
    start_op(8'h01, 8'h02, 17'd0, 0, 16'h0bad);
    repeat (5) @(negedge clk);
    chk("midrun_en", {63'b0, core_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrun_core_rst", {63'b0, core_rst}, 64'd1);
    chk("midrun_core_en", {63'b0, core_en}, 64'd0);
    chk("midrun_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrun_out_data", {48'b0, out_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_valid", {63'b0, out_valid}, 64'd0);
    chk("post_rst_ready", {63'b0, in_ready}, 64'd1);
    run_op(tbl[3]);

`ifdef DSC_SEQ_PERF_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("perf_rst_ops", 64'(perf_ops), 64'd0);
    run_op('{1'b0, 8'd1, 8'd1, 17'd0, 10, 16'h0001, 10, 1'b0, 1'b0});
    run_op('{1'b0, 8'd2, 8'd2, 17'd20, 0, 16'h0002, 20, 1'b1, 1'b0});
    run_op('{1'b0, 8'd3, 8'd3, 17'd0, 30, 16'h0003, 30, 1'b0, 1'b0});
    chk("perf_ops", 64'(perf_ops), 64'd3);
    chk("perf_cycles", 64'(perf_cycles), 64'd60);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsc_op_sequencer.md
DSC_OP_SEQUENCER -- requirements
Module: dsc_op_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of each operand and of each result lane.
REQ-002 SHALL have parameter NUM_INPUTS, default 2: number of operands per operation.
REQ-003 SHALL have parameter CNT_WIDTH, default 17: width of the run-cycle counter and of the budget.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1: operand set offered.
REQ-007 SHALL have port in_ready, output, 1: sequencer accepts an operand set.
REQ-008 SHALL have port in_data, input, NUM_INPUTS*DATA_WIDTH: packed operands, operand i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port cyc_budget, input, CNT_WIDTH: run-cycle cap; 0 means run to completion.
REQ-010 SHALL have port core_rst, output, 1: active-high reset to the DSC core.
REQ-011 SHALL have port core_en, output, 1: enable to the DSC core.
REQ-012 SHALL have port core_data_in, output, NUM_INPUTS*DATA_WIDTH: registered operands to the core.
REQ-013 SHALL have port core_data_out, input, NUM_INPUTS*DATA_WIDTH: core binary result.
REQ-014 SHALL have port core_op_finished, input, 1: core completion flag.
REQ-015 SHALL have port out_valid, output, 1: result available.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-017 SHALL have port out_data, output, NUM_INPUTS*DATA_WIDTH: latched core result.
REQ-018 SHALL have port out_cycles, output, CNT_WIDTH: run cycles consumed, used as the result denominator downstream.
REQ-019 SHALL have port out_trunc, output, 1: run was stopped by the budget before the core finished.
REQ-020 SHALL have port out_ovf, output, 1: run was stopped by counter saturation.

Function
REQ-021 SHALL implement a four-state FSM: IDLE, CLEAR, RUN and DONE.
REQ-022 SHALL, in IDLE: drive in_ready=1, core_rst=1 and core_en=0; when in_valid=1, capture in_data into core_data_in, capture cyc_budget, and move to CLEAR.
REQ-023 SHALL, in CLEAR: hold for exactly 1 cycle with core_rst=1 and core_en=0, clear the counter to 0, then move to RUN.
REQ-024 SHALL, in RUN: drive core_rst=0 and core_en=1, and increment the counter by 1 every cycle.
REQ-025 SHALL define the count value in any RUN cycle as the number of RUN cycles including the current one.
REQ-026 SHALL, in RUN, terminate on the first of three conditions: core_op_finished=1; budget nonzero and count equal to budget; count equal to all-ones.
REQ-027 SHALL, on termination, in that same edge: latch core_data_out into out_data and the count into out_cycles, set the flags, and move to DONE.
REQ-028 SHALL resolve simultaneous termination conditions with core_op_finished taking priority: out_trunc=0 and out_ovf=0.
REQ-029 SHALL set out_ovf=1 only when saturation is the sole cause, with out_trunc=0; when budget and saturation coincide, out_trunc=1 and out_ovf=0.
REQ-030 SHALL, in DONE: drive out_valid=1, core_rst=1 and core_en=0, and hold all output data stable until out_ready=1, then move to IDLE.
REQ-031 SHALL keep out_valid low during the cycle in which DONE moves to IDLE, so there are no back-to-back results.
REQ-032 SHALL drive in_ready=0 in every state except IDLE.
REQ-033 SHALL have an accept-to-first-RUN latency of 2 cycles, and SHALL assert out_valid on the cycle after the terminating RUN cycle.
REQ-034 SHALL hold core_data_in constant from capture until the next capture.
REQ-035 SHALL ignore core_op_finished outside RUN.

Reset
REQ-036 SHALL, while rst_n=0 (async assert, sync release), reset as follows: state IDLE; counter 0; core_rst=1; core_en=0; in_ready=0; out_valid=0; out_data, out_cycles, out_trunc, out_ovf and core_data_in all 0.
REQ-037 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts.
REQ-038 SHALL, on reset asserted during RUN or DONE, abandon the operation: no out_valid and no partial result.

Configuration
REQ-039 SHALL, with macro DSC_SEQ_PERF_EN defined, add output perf_ops[31:0], counting DONE-to-IDLE handshakes (wraps).
REQ-040 SHALL, with DSC_SEQ_PERF_EN defined, add output perf_cycles[47:0], accumulating out_cycles at each handshake (wraps).
REQ-041 SHALL reset both perf counters to 0 by rst_n.
REQ-042 SHALL, without DSC_SEQ_PERF_EN, omit the perf ports and logic, with all other behaviour unchanged.

Verification
REQ-043 SHALL cover: operands 3,5, budget 0, core finishes in RUN cycle 40 -> out_valid at cycle 41 of RUN, out_cycles=40, out_trunc=0, out_ovf=0, out_data = core value.
REQ-044 SHALL cover: budget 16, core never finishes -> out_cycles=16, out_trunc=1; core_en high exactly 16 cycles.
REQ-045 SHALL cover: budget 16, core_op_finished rises in RUN cycle 16 -> out_trunc=0, out_cycles=16.
REQ-046 SHALL cover: CNT_WIDTH=4, budget 0, no finish -> out_cycles=15, out_ovf=1.
REQ-047 SHALL cover: out_ready held low 10 cycles in DONE -> outputs stable and in_ready=0 throughout; in_valid in IDLE is accepted one cycle after the handshake.
REQ-048 SHALL cover: rst_n pulsed low mid-RUN -> core_rst=1 immediately, no out_valid, next operation runs normally; with DSC_SEQ_PERF_EN, 3 completed ops of 10, 20 and 30 cycles -> perf_ops=3, perf_cycles=60.
